// File: rtl/hwemu_rst_sequencer.sv
// Reset/run sequencer for the emulation trace flow. It drives the DUT reset through
// a programmable assert and settle sequence, then opens a counted trace window.
module hwemu_rst_sequencer #(
  parameter int unsigned CNT_W          = 64,
  parameter int unsigned SETTLE_CYC     = 3,
  parameter logic        DUT_RST_ACTIVE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [31:0]      cfg_rst_cycles,
  input  logic [CNT_W-1:0] cfg_run_cycles,
  input  logic             start,
  input  logic             abort,
  output logic             dut_rst,
  output logic             trace_en,
  output logic [CNT_W-1:0] clkcnt,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  localparam int unsigned      SET_W    = $clog2(SETTLE_CYC + 1);
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYC);
  localparam logic [SET_W-1:0] SET_ONE  = SET_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    RST_ASSERT,
    SETTLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [31:0]      rst_cycles_q;
  logic [CNT_W-1:0] run_cycles_q;
  logic             cfg_loaded;
  logic [31:0]      rst_cnt;
  logic [SET_W-1:0] set_cnt;

  logic             cfg_accept;
  logic             in_seq;
  logic             abort_hit;
  logic             start_hit;
  logic [31:0]      rst_len;
  logic [31:0]      rst_load;
  logic [CNT_W-1:0] clkcnt_inc;
  logic             run_last;

  // NOTE: cfg_ready is the one output decoded combinationally, and only from the
  // state register, so no input-to-output path exists through it.
  assign cfg_ready = (state == IDLE) || (state == DONE);

  always_comb begin
    cfg_accept = cfg_valid && cfg_ready;
    in_seq     = (state == RST_ASSERT) || (state == SETTLE) || (state == RUN);
    abort_hit  = abort && in_seq;
    // Abort wins over a coincident start; a same-cycle config counts as loaded.
    start_hit  = start && !abort && cfg_ready && (cfg_loaded || cfg_valid);
    rst_len    = cfg_accept ? cfg_rst_cycles : rst_cycles_q;
    rst_load   = (rst_len == 32'd0) ? 32'd1 : rst_len;
    clkcnt_inc = (&clkcnt) ? clkcnt : clkcnt + CNT_ONE;
    run_last   = (run_cycles_q != '0) && (clkcnt_inc == run_cycles_q);
  end

  // NOTE: every register here is sequential state, so only non-blocking
  // assignments are used; blocking ones would race with the other blocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      dut_rst      <= DUT_RST_ACTIVE;
      trace_en     <= 1'b0;
      clkcnt       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      rst_cycles_q <= '0;
      run_cycles_q <= '0;
      cfg_loaded   <= 1'b0;
      rst_cnt      <= '0;
      set_cnt      <= '0;
    end else begin
      if (cfg_accept) begin
        rst_cycles_q <= cfg_rst_cycles;
        run_cycles_q <= cfg_run_cycles;
        cfg_loaded   <= 1'b1;
      end

      if (abort_hit) begin
        // Aborted runs park in DONE with the DUT held in reset and clkcnt frozen.
        state    <= DONE;
        dut_rst  <= DUT_RST_ACTIVE;
        trace_en <= 1'b0;
        busy     <= 1'b0;
        done     <= 1'b0;
        aborted  <= 1'b1;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start_hit) begin
              state    <= RST_ASSERT;
              dut_rst  <= DUT_RST_ACTIVE;
              trace_en <= 1'b0;
              busy     <= 1'b1;
              done     <= 1'b0;
              aborted  <= 1'b0;
              clkcnt   <= '0;
              rst_cnt  <= rst_load;
            end
          end

          RST_ASSERT: begin
            if (rst_cnt == 32'd1) begin
              state   <= SETTLE;
              dut_rst <= ~DUT_RST_ACTIVE;
              set_cnt <= SET_LOAD;
            end else begin
              rst_cnt <= rst_cnt - 32'd1;
            end
          end

          SETTLE: begin
            if (set_cnt == SET_ONE) begin
              state    <= RUN;
              trace_en <= 1'b1;
            end else begin
              set_cnt <= set_cnt - SET_ONE;
            end
          end

          RUN: begin
            clkcnt <= clkcnt_inc;
            if (run_last) begin
              state    <= DONE;
              trace_en <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end

          default: begin
            state    <= IDLE;
            dut_rst  <= DUT_RST_ACTIVE;
            trace_en <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hwemu_rst_sequencer.sv
// Randomized bench for hwemu_rst_sequencer against a timeline-based reference model
// that predicts every output from the edge at which the current run started.
module tb_hwemu_rst_sequencer;

  localparam int CNT_W   = 8;
  localparam int SETTLE  = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [31:0]      cfg_rst_cycles = '0;
  logic [CNT_W-1:0] cfg_run_cycles = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             dut_rst;
  logic             trace_en;
  logic [CNT_W-1:0] clkcnt;
  logic             busy;
  logic             done;
  logic             aborted;

  hwemu_rst_sequencer #(
    .CNT_W         (CNT_W),
    .SETTLE_CYC    (SETTLE),
    .DUT_RST_ACTIVE(1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_rst_cycles(cfg_rst_cycles),
    .cfg_run_cycles(cfg_run_cycles),
    .start         (start),
    .abort         (abort),
    .dut_rst       (dut_rst),
    .trace_en      (trace_en),
    .clkcnt        (clkcnt),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a run is described by its start edge, reset length and run length.
  bit m_loaded, m_started, m_aborted;
  int m_rst_cfg, m_run_cfg, m_e, m_r, m_run, m_abort_cnt, m_n;
  bit e_dut_rst, e_trace, e_busy, e_done, e_abt, e_ready;
  int e_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, m_n);
    end
  endtask

  task automatic model_reset();
    m_loaded  = 1'b0;
    m_started = 1'b0;
    m_aborted = 1'b0;
    m_rst_cfg = 0;
    m_run_cfg = 0;
  endtask

  task automatic model_eval();
    int k;
    e_dut_rst = 1'b1; e_trace = 1'b0; e_busy = 1'b0;
    e_done = 1'b0; e_abt = 1'b0; e_cnt = 0;
    if (m_started && m_aborted) begin
      e_abt = 1'b1;
      e_cnt = m_abort_cnt;
    end else if (m_started) begin
      k = m_n - m_e;
      if (k < m_r) begin
        e_busy = 1'b1;
      end else if (k < m_r + SETTLE) begin
        e_busy = 1'b1; e_dut_rst = 1'b0;
      end else if (m_run == 0 || k < m_r + SETTLE + m_run) begin
        e_busy = 1'b1; e_dut_rst = 1'b0; e_trace = 1'b1;
        e_cnt = (k - m_r - SETTLE > CNT_MAX) ? CNT_MAX : k - m_r - SETTLE;
      end else begin
        e_dut_rst = 1'b0; e_done = 1'b1; e_cnt = m_run;
      end
    end
    e_ready = !e_busy;
  endtask

  task automatic model_update(input bit cv, input int crst, input int crun,
                              input bit st, input bit ab);
    bit accept;
    accept = cv && e_ready;
    m_n++;
    if (ab && e_busy) begin
      m_aborted   = 1'b1;
      m_abort_cnt = e_cnt;
    end else if (st && !ab && e_ready && (m_loaded || cv)) begin
      m_started = 1'b1;
      m_aborted = 1'b0;
      m_e       = m_n;
      m_r       = accept ? crst : m_rst_cfg;
      if (m_r == 0) m_r = 1;
      m_run     = accept ? crun : m_run_cfg;
    end
    if (accept) begin
      m_rst_cfg = crst;
      m_run_cfg = crun;
      m_loaded  = 1'b1;
    end
    model_eval();
  endtask

  task automatic compare_all();
    check("dut_rst",   64'(dut_rst),   64'(e_dut_rst));
    check("trace_en",  64'(trace_en),  64'(e_trace));
    check("clkcnt",    64'(clkcnt),    64'(e_cnt));
    check("busy",      64'(busy),      64'(e_busy));
    check("done",      64'(done),      64'(e_done));
    check("aborted",   64'(aborted),   64'(e_abt));
    check("cfg_ready", 64'(cfg_ready), 64'(e_ready));
  endtask

  task automatic cycle(input bit cv, input int crst, input int crun, input bit st, input bit ab);
    cfg_valid      = cv;
    cfg_rst_cycles = 32'(crst);
    cfg_run_cycles = CNT_W'(crun);
    start          = st;
    abort          = ab;
    model_update(cv, crst, crun, st, ab);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    m_n = 0;
    model_reset();
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_eval();
    compare_all();

    // Start with no config ever loaded is ignored.
    cycle(1'b0, 0, 0, 1'b1, 1'b0);
    check("start_nocfg", 64'(busy), 64'(0));

    // Nominal run: reset 5, run 10.
    cycle(1'b1, 5, 10, 1'b0, 1'b0);
    cycle(1'b0, 0, 0, 1'b1, 1'b0);
    idle(18);
    check("nom_cnt",  64'(clkcnt), 64'(10));
    check("nom_done", 64'(done),   64'(1));
    idle(3);

    // Zero reset length with config and start in the same cycle.
    cycle(1'b1, 0, 3, 1'b1, 1'b0);
    idle(10);
    check("zero_cnt", 64'(clkcnt), 64'(3));

    // Unlimited run aborted after 100 RUN cycles; ignored commands mid-run.
    cycle(1'b1, 2, 0, 1'b1, 1'b0);
    idle(50);
    cycle(1'b1, 7, 9, 1'b1, 1'b0);
    idle(54);
    cycle(1'b0, 0, 0, 1'b0, 1'b1);
    check("abort_cnt", 64'(clkcnt),  64'(100));
    check("abort_flg", 64'(aborted), 64'(1));
    check("abort_rst", 64'(dut_rst), 64'(1));
    idle(2);

    // Restart from stored config and run into counter saturation.
    cycle(1'b0, 0, 0, 1'b1, 1'b0);
    idle(305);
    check("sat_cnt", 64'(clkcnt), 64'(CNT_MAX));
    cycle(1'b0, 0, 0, 1'b0, 1'b1);

    // Asynchronous reset between edges while in RUN.
    cycle(1'b0, 0, 0, 1'b1, 1'b0);
    idle(10);
    rst = 1'b0;
    #1;
    check("arst_dut_rst", 64'(dut_rst),  64'(1));
    check("arst_trace",   64'(trace_en), 64'(0));
    check("arst_cnt",     64'(clkcnt),   64'(0));
    check("arst_busy",    64'(busy),     64'(0));
    check("arst_ready",   64'(cfg_ready), 64'(1));
    model_reset();
    model_eval();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b1;
    cycle(1'b0, 0, 0, 1'b1, 1'b0);
    check("arst_noload", 64'(busy), 64'(0));

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      bit cv, st, ab;
      int crst, crun;
      cv   = ($urandom_range(7, 0) == 0);
      st   = ($urandom_range(9, 0) == 0);
      ab   = ($urandom_range(39, 0) == 0);
      if (ab) st = 1'b0;
      crst = $urandom_range(6, 0);
      crun = ($urandom_range(7, 0) == 0) ? 0 : $urandom_range(40, 1);
      cycle(cv, crst, crun, st, ab);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
